// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// Status bit positions match the ALU status byte.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

   localparam int ST_ZERO = 7;
   localparam int ST_NEG  = 4;
   localparam int ST_DIV0 = 2;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: add-and-shift-right for multiply,
// restoring shift-left-and-subtract for divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] acc_nxt
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   top;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      // multiply: {product_hi, remaining multiplier bits}, multiplicand in b
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b : {WIDTH{1'b0}})};
      // divide: {remainder, dividend/quotient}; top holds the shifted-out bit
      top  = acc[2*WIDTH-1:WIDTH-1];
      ge   = (top >= {1'b0, b});
      diff = top[WIDTH-1:0] - b;
      if (is_div)
         acc_nxt = ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
      else
         acc_nxt = {sum, acc[WIDTH-1:1]};
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: WIDTH iterations on magnitudes,
// then a one-cycle sign fixup that loads hi/lo/status.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [7:0]       status
);

   state_t             state;
   logic               div_r, neg_lo, neg_hi;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   b_r;
   logic [2*WIDTH-1:0] acc, acc_nxt;

   logic               is_div, is_sgn, a_neg, b_neg, accept, div0;
   logic [WIDTH-1:0]   a_abs, b_abs;

   always_comb begin
      is_div = (op == OP_DIV) || (op == OP_DIVU);
      is_sgn = (op == OP_MULT) || (op == OP_DIV);
      a_neg  = is_sgn & op_a[WIDTH-1];
      b_neg  = is_sgn & op_b[WIDTH-1];
      a_abs  = a_neg ? -op_a : op_a;
      b_abs  = b_neg ? -op_b : op_b;
      accept = start & ~flush & ((state == S_IDLE) || (state == S_DONE));
      div0   = is_div & (op_b == '0);
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (div_r),
      .acc     (acc),
      .b       (b_r),
      .acc_nxt (acc_nxt)
   );

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic [7:0]         fix_st;

   always_comb begin
      prod   = neg_lo ? -acc : acc;
      fix_st = '0;
      if (div_r) begin
         // quotient truncates toward zero; remainder follows the dividend
         fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
         fix_st[ST_ZERO] = (fix_lo == '0);
         fix_st[ST_NEG]  = fix_lo[WIDTH-1];
      end else begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
         fix_st[ST_ZERO] = (prod == '0);
         fix_st[ST_NEG]  = prod[2*WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         status <= '0;
         cnt    <= '0;
         acc    <= '0;
         b_r    <= '0;
         div_r  <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (accept && div0) begin
                  state          <= S_DONE;
                  done           <= 1'b1;
                  status         <= '0;
                  status[ST_DIV0] <= 1'b1;
               end else if (accept) begin
                  state  <= S_CALC;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  div_r  <= is_div;
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= a_neg;
                  acc    <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
                  b_r    <= is_div ? b_abs : a_abs;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc <= acc_nxt;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(WIDTH-1)) state <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               state <= flush ? S_IDLE : S_DONE;
               busy  <= 1'b0;
               if (!flush) begin
                  hi     <= fix_hi;
                  lo     <= fix_lo;
                  status <= fix_st;
                  done   <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench: stimulus predicts results with plain 64-bit arithmetic,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

   localparam int W = 32;

   logic         clk, rst_n, start, flush, busy, done;
   logic [1:0]   op;
   logic [W-1:0] op_a, op_b, hi, lo;
   logic [7:0]   status;

   muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .status(status)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [7:0]  st;
      int          cyc;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          total = 0, bad = 0, cyc = 0;
   logic [31:0] mh, ml;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sb, sp;
      logic [63:0] p;
      e.cyc = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o[1] && b == 0) begin
         e.hi = mh; e.lo = ml; e.st = 8'h04;
         return e;
      end
      case (o)
         2'd0: begin sp = sa * sb; p = sp; end
         2'd1: p = {32'b0, a} * {32'b0, b};
         2'd2: p = {32'(sa % sb), 32'(sa / sb)};
         default: p = {a % b, a / b};
      endcase
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.st = 8'h00;
      if (!o[1]) begin
         e.st[7] = (p == 64'd0);
         e.st[4] = p[63];
      end else begin
         e.st[7] = (e.lo == 32'd0);
         e.st[4] = e.lo[31];
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
         end else begin
            mon_e = sbq.pop_front();
            check("hi", hi, mon_e.hi);
            check("lo", lo, mon_e.lo);
            check("status", status, mon_e.st);
            check("done_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
      exp_t e;
      start = 1'b1; op = o; op_a = a; op_b = b;
      if (push) begin
         e = model(o, a, b);
         e.cyc = (o[1] && b == 0) ? cyc + 1 : cyc + W + 2;
         sbq.push_back(e);
         mh = e.hi;
         ml = e.lo;
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (!done && n < bound) begin @(posedge clk); #1; n++; end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout: got done=0 want done=1 within %0d cycles", bound);
      end
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; op_a = '0; op_b = '0;
      mh = '0; ml = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_status", status, 0);
      rst_n = 1'b1;
      idle(1);

      issue(2'd0, 32'd7, 32'hFFFF_FFFD, 1);       wait_done(40); idle(1);
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done(40); idle(1);
      issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1);       wait_done(40); idle(1);
      issue(2'd3, 32'd0, 32'd5, 1);               wait_done(40); idle(1);
      issue(2'd3, 32'd7, 32'd3, 1);               wait_done(40); idle(1);
      issue(2'd3, 32'd10, 32'd0, 1);
      check("div0_busy", busy, 0);
      wait_done(5); idle(1);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done(40); idle(1);

      // flush mid-CALC, then a fresh op with ignored start pulses while busy
      issue(2'd0, 32'd12345, 32'd678, 0);
      idle(10);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      check("flush_busy", busy, 0);
      issue(2'd1, 32'hDEAD_BEEF, 32'h0000_1234, 1);
      repeat (3) begin
         start = 1'b1; op = 2'd2; op_a = $urandom; op_b = $urandom;
         idle(1);
         start = 1'b0;
         idle(1);
      end
      check("busy_hold", busy, 1);
      wait_done(40); idle(2);

      // flush in IDLE drops a simultaneous start
      start = 1'b1; flush = 1'b1; op = 2'd3; op_a = 32'd1; op_b = 32'd0;
      idle(1);
      start = 1'b0; flush = 1'b0;
      check("flush_drop_done", done, 0);
      check("flush_drop_busy", busy, 0);
      idle(3);

      issue(2'd3, 32'd100, 32'd7, 1); wait_done(40);
      issue(2'd3, 32'd100, 32'd7, 1); wait_done(40); idle(1);

      for (int i = 0; i < 24; i++) begin
         issue(2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1);
         wait_done(40);
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(1);

      // reset mid-CALC discards the operation
      issue(2'd0, 32'h1111_1111, 32'd3, 0);
      idle(10);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      check("midrst_status", status, 0);
      mh = '0; ml = '0;
      idle(1);
      rst_n = 1'b1;
      idle(W + 5);
      issue(2'd3, 32'd9, 32'd0, 1); wait_done(5); idle(2);

      check("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
